mips32_mem_arbiter: RTL and testbench

//  Shares the single-port unified instruction/data memory of the MIPS32 core between two requesters:
//   - the IF stage (fetch port, read-only);
//   - the MEM stage (data port, LW/SW).
//  Req/gnt handshake per port; one transaction outstanding at a time. Data port has fixed priority.
//  A starvation counter guarantees fetch progress under a sustained data-port load.

---
 rtl/mips32_pkg.sv | 18 +
 rtl/mips32_mem_arbiter_if.sv | 43 ++++
 rtl/mips32_arb_pick.sv | 13 +
 rtl/mips32_mem_arbiter.sv | 140 ++++++++++++++
 tb/tb_mips32_mem_arbiter.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/mips32_pkg.sv
// Shared types and default widths for the MIPS32 unified-memory arbiter slice.
package mips32_pkg;

  localparam int ADDR_W_DEF = 10;
  localparam int DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_IF,
    OWN_DM
  } owner_e;

  typedef enum logic {
    ST_IDLE,
    ST_RD_WAIT
  } state_e;

endpackage

// File: rtl/mips32_mem_arbiter_if.sv
// Bundle of fetch-port, data-port and memory-side signals around the memory arbiter.
interface mips32_mem_arbiter_if
  import mips32_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);

  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;

  logic              dm_req;
  logic              dm_we;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic              dm_gnt;
  logic              dm_rvalid;
  logic [DATA_W-1:0] dm_rdata;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  // The arbiter side.
  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
    output if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata,
           mem_en, mem_we, mem_addr, mem_wdata
  );

  // The requesters and the memory, seen from outside the arbiter.
  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata,
           mem_en, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/mips32_arb_pick.sv
// Two-way fixed-priority picker: data port wins unless the fetch port is being forced.
module mips32_arb_pick (
  input  logic dm_req,
  input  logic if_req,
  input  logic force_if,
  output logic dm_gnt,
  output logic if_gnt
);

  assign if_gnt = if_req & (force_if | ~dm_req);
  assign dm_gnt = dm_req & ~(force_if & if_req);

endmodule

// File: rtl/mips32_mem_arbiter.sv
// Shares one single-port memory between the IF (fetch) and MEM (data) stages,
// one transaction outstanding, data priority with a starvation guard for fetch.
module mips32_mem_arbiter
  import mips32_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input logic                 clk,
  input logic                 rst_n,
  mips32_mem_arbiter_if.slave bus
);

  localparam int LW = $clog2(MEM_LAT + 1);
  localparam int SW = $clog2(STARVE_MAX + 1);

  state_e            state, state_nxt;
  owner_e            owner, owner_nxt;
  logic [LW-1:0]     lat_cnt, lat_nxt;
  logic [SW-1:0]     starve_cnt, starve_nxt;

  logic              arb_en;
  logic              force_if;
  logic              if_gnt;
  logic              dm_gnt;
  logic              rd_done;
  logic [ADDR_W-1:0] addr_sel;
  logic [DATA_W-1:0] wdata_sel;

  // Grants are only offered from IDLE and never while reset is held.
  assign arb_en   = rst_n & (state == ST_IDLE);
  assign force_if = (starve_cnt == SW'(STARVE_MAX));
  assign rd_done  = rst_n & (state == ST_RD_WAIT) & (lat_cnt == '0);

  mips32_arb_pick u_pick (
    .dm_req   (bus.dm_req & arb_en),
    .if_req   (bus.if_req & arb_en),
    .force_if (force_if),
    .dm_gnt   (dm_gnt),
    .if_gnt   (if_gnt)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its peers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      owner      <= OWN_NONE;
      lat_cnt    <= '0;
      starve_cnt <= '0;
    end else begin
      state      <= state_nxt;
      owner      <= owner_nxt;
      lat_cnt    <= lat_nxt;
      starve_cnt <= starve_nxt;
    end
  end

  // NOTE: every always_comb output gets a default first so no path leaves
  // it unassigned, which would infer a latch.
  always_comb begin
    state_nxt  = state;
    owner_nxt  = owner;
    lat_nxt    = lat_cnt;
    starve_nxt = starve_cnt;

    case (state)
      ST_IDLE: begin
        if (if_gnt) begin
          state_nxt = ST_RD_WAIT;
          owner_nxt = OWN_IF;
          lat_nxt   = LW'(MEM_LAT - 1);
        end else if (dm_gnt && !bus.dm_we) begin
          state_nxt = ST_RD_WAIT;
          owner_nxt = OWN_DM;
          lat_nxt   = LW'(MEM_LAT - 1);
        end
      end
      ST_RD_WAIT: begin
        if (lat_cnt == '0) begin
          state_nxt = ST_IDLE;
          owner_nxt = OWN_NONE;
        end else begin
          lat_nxt = lat_cnt - LW'(1);
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        owner_nxt = OWN_NONE;
      end
    endcase

    // Count data grants that overtake a waiting fetch.
    if (!bus.if_req || if_gnt) begin
      starve_nxt = '0;
    end else if (dm_gnt && !force_if) begin
      starve_nxt = starve_cnt + SW'(1);
    end
  end

  always_comb begin
    addr_sel      = '0;
    wdata_sel     = '0;
    bus.mem_en    = 1'b0;
    bus.mem_we    = 1'b0;
    bus.if_rvalid = 1'b0;
    bus.if_rdata  = '0;
    bus.dm_rvalid = 1'b0;
    bus.dm_rdata  = '0;

    if (dm_gnt) begin
      bus.mem_en = 1'b1;
      bus.mem_we = bus.dm_we;
      addr_sel   = bus.dm_addr;
      wdata_sel  = bus.dm_we ? bus.dm_wdata : '0;
    end else if (if_gnt) begin
      bus.mem_en = 1'b1;
      addr_sel   = bus.if_addr;
    end

    // Read data is steered only to the port that owns the outstanding read.
    if (rd_done) begin
      if (owner == OWN_IF) begin
        bus.if_rvalid = 1'b1;
        bus.if_rdata  = bus.mem_rdata;
      end else if (owner == OWN_DM) begin
        bus.dm_rvalid = 1'b1;
        bus.dm_rdata  = bus.mem_rdata;
      end
    end

    bus.if_gnt    = if_gnt;
    bus.dm_gnt    = dm_gnt;
    bus.mem_addr  = addr_sel;
    bus.mem_wdata = wdata_sel;
  end

endmodule

// File: tb/tb_mips32_mem_arbiter.sv
// Directed bench for mips32_mem_arbiter: one instance with MEM_LAT=1, one with MEM_LAT=3.
module tb_mips32_mem_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  mips32_mem_arbiter_if #(.ADDR_W(10), .DATA_W(32)) bus1 ();
  mips32_mem_arbiter_if #(.ADDR_W(10), .DATA_W(32)) bus3 ();

  mips32_mem_arbiter #(.ADDR_W(10), .DATA_W(32), .MEM_LAT(1), .STARVE_MAX(4)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1)
  );
  mips32_mem_arbiter #(.ADDR_W(10), .DATA_W(32), .MEM_LAT(3), .STARVE_MAX(4)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .bus(bus3)
  );

  // Behavioural memories: mem1 returns data 1 cycle after mem_en, mem3 after 3.
  logic [31:0] mem1 [1024];
  logic [31:0] mem3 [1024];
  logic [31:0] rd1;
  logic [31:0] p3 [3];

  initial begin
    for (int i = 0; i < 1024; i++) begin
      mem1[i] <= 32'hA5A5_0000 | 32'(i);
      mem3[i] <= 32'hA5A5_0000 | 32'(i);
    end
    mem1[5] <= 32'h2820_0001;
    mem3[5] <= 32'h2820_0001;
    rd1 <= 32'h0;
    for (int i = 0; i < 3; i++) p3[i] <= 32'h0;
  end

  always @(posedge clk) begin
    if (bus1.mem_en && bus1.mem_we) mem1[bus1.mem_addr] <= bus1.mem_wdata;
    else if (bus1.mem_en) rd1 <= mem1[bus1.mem_addr];
  end
  assign bus1.mem_rdata = rd1;

  always @(posedge clk) begin
    if (bus3.mem_en && bus3.mem_we) mem3[bus3.mem_addr] <= bus3.mem_wdata;
    p3[0] <= (bus3.mem_en && !bus3.mem_we) ? mem3[bus3.mem_addr] : 32'h0;
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end
  assign bus3.mem_rdata = p3[2];

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    next_cycle();
    #1;
    total++; if (bus1.if_gnt !== 1'b0 || bus1.dm_gnt !== 1'b0) begin bad++; $display("FAIL rst_gnt got if=%b dm=%b exp 0/0", bus1.if_gnt, bus1.dm_gnt); end
    total++; if (bus1.mem_en !== 1'b0 || bus1.if_rvalid !== 1'b0 || bus1.dm_rvalid !== 1'b0) begin bad++; $display("FAIL rst_en_rvalid got en=%b ifv=%b dmv=%b exp 0", bus1.mem_en, bus1.if_rvalid, bus1.dm_rvalid); end
    // Requests during reset must not be granted.
    bus1.if_req = 1'b1; bus1.dm_req = 1'b1; bus1.dm_we = 1'b1; bus1.dm_wdata = 32'h1234_5678;
    #1;
    total++; if (bus1.if_gnt !== 1'b0 || bus1.dm_gnt !== 1'b0 || bus1.mem_we !== 1'b0) begin bad++; $display("FAIL rst_req_gnt got if=%b dm=%b we=%b exp 0", bus1.if_gnt, bus1.dm_gnt, bus1.mem_we); end
    total++; if (bus1.mem_wdata !== 32'h0 || bus1.mem_addr !== 10'h0) begin bad++; $display("FAIL rst_data got wdata=%h addr=%h exp 0", bus1.mem_wdata, bus1.mem_addr); end
    next_cycle();
    bus1.if_req = 1'b0; bus1.dm_req = 1'b0; bus1.dm_we = 1'b0; bus1.dm_wdata = 32'h0;
    rst_n = 1'b1;
    next_cycle();
    #1;
    total++; if (bus1.if_gnt !== 1'b0 || bus1.dm_gnt !== 1'b0 || bus1.mem_en !== 1'b0) begin bad++; $display("FAIL idle_after_rst got if=%b dm=%b en=%b exp 0", bus1.if_gnt, bus1.dm_gnt, bus1.mem_en); end
    total++; if (bus3.if_gnt !== 1'b0 || bus3.if_rvalid !== 1'b0 || bus3.mem_en !== 1'b0) begin bad++; $display("FAIL idle_after_rst3 got gnt=%b v=%b en=%b exp 0", bus3.if_gnt, bus3.if_rvalid, bus3.mem_en); end
  endtask

  task automatic test_single_fetch();
    next_cycle();
    bus1.if_req = 1'b1; bus1.if_addr = 10'h005;
    #1;
    total++; if (bus1.if_gnt !== 1'b1 || bus1.dm_gnt !== 1'b0) begin bad++; $display("FAIL fetch_gnt got if=%b dm=%b exp 1/0", bus1.if_gnt, bus1.dm_gnt); end
    total++; if (bus1.mem_en !== 1'b1 || bus1.mem_we !== 1'b0 || bus1.mem_addr !== 10'h005) begin bad++; $display("FAIL fetch_mem got en=%b we=%b addr=%h exp 1/0/005", bus1.mem_en, bus1.mem_we, bus1.mem_addr); end
    next_cycle();
    bus1.if_req = 1'b0;
    #1;
    total++; if (bus1.if_rvalid !== 1'b1 || bus1.if_rdata !== 32'h2820_0001) begin bad++; $display("FAIL fetch_rdata got v=%b d=%h exp 1/28200001", bus1.if_rvalid, bus1.if_rdata); end
    total++; if (bus1.dm_rvalid !== 1'b0 || bus1.dm_rdata !== 32'h0 || bus1.if_gnt !== 1'b0) begin bad++; $display("FAIL fetch_other got dmv=%b dmd=%h gnt=%b exp 0", bus1.dm_rvalid, bus1.dm_rdata, bus1.if_gnt); end
    next_cycle();
    #1;
    total++; if (bus1.if_rvalid !== 1'b0 || bus1.if_rdata !== 32'h0) begin bad++; $display("FAIL fetch_pulse got v=%b d=%h exp 0/0", bus1.if_rvalid, bus1.if_rdata); end
  endtask

  task automatic test_simultaneous();
    next_cycle();
    bus1.if_req = 1'b1; bus1.if_addr = 10'h007;
    bus1.dm_req = 1'b1; bus1.dm_we = 1'b0; bus1.dm_addr = 10'h010;
    #1;
    total++; if (bus1.dm_gnt !== 1'b1 || bus1.if_gnt !== 1'b0 || bus1.mem_addr !== 10'h010) begin bad++; $display("FAIL sim_T got dm=%b if=%b addr=%h exp 1/0/010", bus1.dm_gnt, bus1.if_gnt, bus1.mem_addr); end
    next_cycle();
    bus1.dm_req = 1'b0;
    #1;
    total++; if (bus1.dm_rvalid !== 1'b1 || bus1.dm_rdata !== 32'hA5A5_0010) begin bad++; $display("FAIL sim_dm_rdata got v=%b d=%h exp 1/a5a50010", bus1.dm_rvalid, bus1.dm_rdata); end
    total++; if (bus1.if_gnt !== 1'b0 || bus1.if_rvalid !== 1'b0) begin bad++; $display("FAIL sim_T1_if got gnt=%b v=%b exp 0/0", bus1.if_gnt, bus1.if_rvalid); end
    next_cycle();
    #1;
    total++; if (bus1.if_gnt !== 1'b1 || bus1.mem_addr !== 10'h007) begin bad++; $display("FAIL sim_T2_if_gnt got gnt=%b addr=%h exp 1/007", bus1.if_gnt, bus1.mem_addr); end
    next_cycle();
    bus1.if_req = 1'b0;
    #1;
    total++; if (bus1.if_rvalid !== 1'b1 || bus1.if_rdata !== 32'hA5A5_0007 || bus1.dm_rvalid !== 1'b0) begin bad++; $display("FAIL sim_T3_if got v=%b d=%h dmv=%b exp 1/a5a50007/0", bus1.if_rvalid, bus1.if_rdata, bus1.dm_rvalid); end
  endtask

  task automatic test_starvation();
    int cnt = 0;
    int ifs = 0;
    int runs [2] = '{0, 0};
    logic both = 1'b0;
    next_cycle();
    bus1.if_req = 1'b1; bus1.if_addr = 10'h009;
    bus1.dm_req = 1'b1; bus1.dm_we = 1'b1; bus1.dm_addr = 10'h020; bus1.dm_wdata = 32'h0;
    #1;
    for (int c = 0; c < 30; c++) begin
      if (bus1.dm_gnt && bus1.if_gnt) both = 1'b1;
      if (bus1.dm_gnt) begin
        cnt++;
        bus1.dm_addr = bus1.dm_addr + 10'h1;
        bus1.dm_wdata = bus1.dm_wdata + 32'h1;
      end
      if (bus1.if_gnt) begin
        runs[ifs] = cnt;
        cnt = 0;
        ifs++;
      end
      if (ifs == 2) break;
      next_cycle();
      #1;
    end
    bus1.if_req = 1'b0; bus1.dm_req = 1'b0; bus1.dm_we = 1'b0;
    total++; if (ifs != 2) begin bad++; $display("FAIL starve_if_grants got %0d exp 2 within 30 cycles", ifs); end
    total++; if (runs[0] != 4) begin bad++; $display("FAIL starve_run0 got %0d dm grants exp 4", runs[0]); end
    total++; if (runs[1] != 4) begin bad++; $display("FAIL starve_run1 got %0d dm grants exp 4 after counter reset", runs[1]); end
    total++; if (both !== 1'b0) begin bad++; $display("FAIL starve_both_gnt got %b exp 0", both); end
    next_cycle();
    next_cycle();
  endtask

  task automatic test_store();
    bus1.dm_req = 1'b1; bus1.dm_we = 1'b1; bus1.dm_addr = 10'h3FF; bus1.dm_wdata = 32'hDEAD_BEEF;
    #1;
    total++; if (bus1.dm_gnt !== 1'b1 || bus1.mem_en !== 1'b1 || bus1.mem_we !== 1'b1) begin bad++; $display("FAIL store_gnt got gnt=%b en=%b we=%b exp 1/1/1", bus1.dm_gnt, bus1.mem_en, bus1.mem_we); end
    total++; if (bus1.mem_addr !== 10'h3FF || bus1.mem_wdata !== 32'hDEAD_BEEF) begin bad++; $display("FAIL store_bus got addr=%h wdata=%h exp 3ff/deadbeef", bus1.mem_addr, bus1.mem_wdata); end
    next_cycle();
    bus1.dm_req = 1'b0; bus1.dm_we = 1'b0;
    #1;
    total++; if (bus1.dm_rvalid !== 1'b0 || bus1.mem_wdata !== 32'h0 || bus1.mem_we !== 1'b0) begin bad++; $display("FAIL store_after got v=%b wdata=%h we=%b exp 0/0/0", bus1.dm_rvalid, bus1.mem_wdata, bus1.mem_we); end
    next_cycle();
    bus1.dm_req = 1'b1; bus1.dm_we = 1'b0; bus1.dm_addr = 10'h3FF;
    #1;
    total++; if (bus1.dm_gnt !== 1'b1 || bus1.mem_we !== 1'b0) begin bad++; $display("FAIL load_gnt got gnt=%b we=%b exp 1/0", bus1.dm_gnt, bus1.mem_we); end
    next_cycle();
    bus1.dm_req = 1'b0;
    #1;
    total++; if (bus1.dm_rvalid !== 1'b1 || bus1.dm_rdata !== 32'hDEAD_BEEF) begin bad++; $display("FAIL load_back got v=%b d=%h exp 1/deadbeef", bus1.dm_rvalid, bus1.dm_rdata); end
    next_cycle();
  endtask

  task automatic test_reset_mid_read();
    bus3.if_req = 1'b1; bus3.if_addr = 10'h005;
    #1;
    total++; if (bus3.if_gnt !== 1'b1) begin bad++; $display("FAIL midrst_gnt got %b exp 1", bus3.if_gnt); end
    next_cycle();
    bus3.if_req = 1'b0;
    rst_n = 1'b0;
    #1;
    total++; if (bus3.if_rvalid !== 1'b0) begin bad++; $display("FAIL midrst_T1 got v=%b exp 0", bus3.if_rvalid); end
    next_cycle();
    rst_n = 1'b1;
    #1;
    total++; if (bus3.if_rvalid !== 1'b0) begin bad++; $display("FAIL midrst_T2 got v=%b exp 0", bus3.if_rvalid); end
    next_cycle();
    // A fresh fetch is granted at once, so the arbiter is back in IDLE.
    bus3.if_req = 1'b1; bus3.if_addr = 10'h005;
    #1;
    total++; if (bus3.if_rvalid !== 1'b0) begin bad++; $display("FAIL midrst_T3 got v=%b exp 0", bus3.if_rvalid); end
    total++; if (bus3.if_gnt !== 1'b1) begin bad++; $display("FAIL midrst_idle_gnt got %b exp 1", bus3.if_gnt); end
    next_cycle();
    bus3.if_req = 1'b0;
    #1;
    total++; if (bus3.if_rvalid !== 1'b0 || bus3.if_gnt !== 1'b0) begin bad++; $display("FAIL lat3_T1 got v=%b gnt=%b exp 0/0", bus3.if_rvalid, bus3.if_gnt); end
    next_cycle();
    #1;
    total++; if (bus3.if_rvalid !== 1'b0) begin bad++; $display("FAIL lat3_T2 got v=%b exp 0", bus3.if_rvalid); end
    next_cycle();
    #1;
    total++; if (bus3.if_rvalid !== 1'b1 || bus3.if_rdata !== 32'h2820_0001) begin bad++; $display("FAIL lat3_T3 got v=%b d=%h exp 1/28200001", bus3.if_rvalid, bus3.if_rdata); end
    next_cycle();
    #1;
    total++; if (bus3.if_rvalid !== 1'b0) begin bad++; $display("FAIL lat3_pulse got v=%b exp 0", bus3.if_rvalid); end
  endtask

  initial begin
    bus1.if_req = 1'b0; bus1.if_addr = '0; bus1.dm_req = 1'b0; bus1.dm_we = 1'b0;
    bus1.dm_addr = '0; bus1.dm_wdata = '0;
    bus3.if_req = 1'b0; bus3.if_addr = '0; bus3.dm_req = 1'b0; bus3.dm_we = 1'b0;
    bus3.dm_addr = '0; bus3.dm_wdata = '0;
    test_reset();
    test_single_fetch();
    test_simultaneous();
    test_starvation();
    test_store();
    test_reset_mid_read();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
